priority_req_controller: RTL

Parametrised, registered successor to the combinational 8-to-3 priority encoder. It latches request pulses from N sources into sticky pending bits and applies a per-source mask. Each cycle it selects one eligible source, by fixed or round-robin priority, and presents its index on a valid/ready output handshake. The block sits between interrupt/event sources and a single consumer, such as a sequencer or a CPU interrupt port, that services one source at a time.

---
 rtl/priority_req_controller.sv | 80 ++++++++
 1 files changed

// File: rtl/priority_req_controller.sv
// Sticky-pending request controller: latches request pulses, masks sources, and presents one
// granted source index per handshake using fixed or round-robin priority.
module priority_req_controller #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N),
  parameter int unsigned MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pending,
  output logic             idle
);

  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     eligible;
  logic [N-1:0]     clr;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             load;

  assign eligible = pending_q & ~mask;
  assign load     = (!out_valid_q || out_ready) && (eligible != '0);

  // Candidates are visited from lowest to highest priority so the last hit wins.
  always_comb begin
    sel  = '0;
    cand = '0;
    if (MODE == 0) begin
      for (int i = 0; i < int'(N); i++) begin
        cand = IDX_W'(i);
        if (eligible[cand]) sel = cand;
      end
    end else begin
      // Offset k=1 is ptr-1 (highest priority), k=N is ptr itself (lowest).
      for (int k = int'(N); k >= 1; k--) begin
        cand = IDX_W'((int'(ptr_q) + int'(N) - k) % int'(N));
        if (eligible[cand]) sel = cand;
      end
    end
  end

  always_comb begin
    clr = '0;
    if (load) clr = {{(N-1){1'b0}}, 1'b1} << sel;
    // Set wins over clear so a re-request on the granted bit stays pending.
    pending_d = (pending_q & ~clr) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      pending_q <= pending_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_idx_q   <= sel;
        ptr_q       <= sel;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign idle      = (pending_q == '0) && !out_valid_q;

endmodule
